// File: rtl/alu_result_buffer_if.sv
// Result stream bundle between the ALU, the result buffer and its consumer.
// alu_out is taken whenever alu_valid is high (no backpressure); res_data moves only when res_valid && res_ready.
interface alu_result_buffer_if #(
    parameter int WIDTH = 6
);
    logic [WIDTH:0] alu_out;
    logic           alu_valid;
    logic [WIDTH:0] res_data;
    logic           res_valid;
    logic           res_ready;

    modport master (
        output alu_out, alu_valid, res_ready,
        input  res_data, res_valid
    );

    modport slave (
        input  alu_out, alu_valid, res_ready,
        output res_data, res_valid
    );
endinterface

// File: rtl/alu_result_buffer.sv
// FWFT result buffer behind the ALU: captures every ALU result, replays it under valid/ready,
// and counts results lost while full.
module alu_result_buffer #(
    parameter int WIDTH    = 6,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6,
    parameter int CNT_W    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    alu_result_buffer_if.slave       bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic                     overflow,
    input  logic                     ovf_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH:0]  mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            pop;
    logic            push;
    logic            drop;

    assign bus.res_valid = (count != '0);
    assign bus.res_data  = (count != '0) ? mem[rd_ptr] : '0;
    assign almost_full   = (count >= CW'(AF_LEVEL));

    // A full buffer that is popping in the same cycle still has room for the new result.
    assign pop  = bus.res_valid && bus.res_ready;
    assign push = bus.alu_valid && ((count < CW'(DEPTH)) || pop);
    assign drop = bus.alu_valid && !push;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.alu_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // A drop in the clearing cycle is the first event of the new window.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (ovf_clr) begin
                drop_cnt <= CNT_W'(1);
            end else if (drop_cnt != {CNT_W{1'b1}}) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end else if (ovf_clr) begin
            drop_cnt <= '0;
            overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed and random stimulus for alu_result_buffer against an occupancy model and expected-result queue.
module tb_alu_result_buffer;
    localparam int WIDTH    = 6;
    localparam int DEPTH    = 8;
    localparam int AF_LEVEL = 6;
    localparam int CNT_W    = 8;
    localparam int W        = WIDTH + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       count;
    logic             almost_full;
    logic [CNT_W-1:0] drop_cnt;
    logic             overflow;
    logic             ovf_clr;

    alu_result_buffer_if #(.WIDTH(WIDTH)) bus ();

    alu_result_buffer #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .count(count),
        .almost_full(almost_full),
        .drop_cnt(drop_cnt),
        .overflow(overflow),
        .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    logic [W-1:0] exp_q[$];
    int  m_cnt   = 0;
    int  m_drop  = 0;
    bit  m_ovf   = 1'b0;
    bit  m_known = 1'b0;
    int  n_pass  = 0;
    int  n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic drive(input bit v, input int d, input bit rdy, input bit clr);
        bus.alu_valid = v;
        bus.alu_out   = W'(d);
        bus.res_ready = rdy;
        ovf_clr       = clr;
    endtask

    // Check the current state against the model, clock once, then advance the model.
    task automatic cycle();
        bit pop;
        bit push;
        if (m_known) begin
            chk("res_valid", 32'(bus.res_valid), 32'(m_cnt != 0));
            chk("count", 32'(count), 32'(m_cnt));
            chk("almost_full", 32'(almost_full), 32'(m_cnt >= AF_LEVEL));
            chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            if (m_cnt != 0) chk("res_data", 32'(bus.res_data), 32'(exp_q[0]));
            else            chk("res_data_idle", 32'(bus.res_data), 32'd0);
        end
        pop  = (m_cnt != 0) && bus.res_ready;
        push = bus.alu_valid && ((m_cnt < DEPTH) || pop);
        @(posedge clk);
        #1;
        if (rst) begin
            exp_q.delete();
            m_cnt   = 0;
            m_drop  = 0;
            m_ovf   = 1'b0;
            m_known = 1'b1;
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (push) exp_q.push_back(bus.alu_out);
            m_cnt = m_cnt + int'(push) - int'(pop);
            if (bus.alu_valid && !push) begin
                m_ovf  = 1'b1;
                m_drop = ovf_clr ? 1 : ((m_drop == 255) ? 255 : m_drop + 1);
            end else if (ovf_clr) begin
                m_drop = 0;
                m_ovf  = 1'b0;
            end
        end
    endtask

    task automatic drain(input int n);
        drive(0, 0, 1, 0);
        for (int i = 0; i < n; i++) cycle();
        drive(0, 0, 0, 0);
    endtask

    initial begin
        // Reset with ALU traffic present
        rst = 1'b1;
        drive(1, 5, 0, 0);
        cycle();
        cycle();
        rst = 1'b0;
        drive(0, 0, 0, 0);
        chk("rst_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_data", 32'(bus.res_data), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);

        // Single pass
        drive(1, 12, 0, 0);
        cycle();
        drive(0, 0, 0, 0);
        chk("single_valid", 32'(bus.res_valid), 32'd1);
        chk("single_data", 32'(bus.res_data), 32'd12);
        chk("single_count", 32'(count), 32'd1);
        drive(0, 0, 1, 0);
        cycle();
        drive(0, 0, 0, 0);
        chk("single_empty_valid", 32'(bus.res_valid), 32'd0);
        chk("single_empty_data", 32'(bus.res_data), 32'd0);
        chk("single_empty_count", 32'(count), 32'd0);

        // Fill past full
        for (int i = 1; i <= 10; i++) begin
            drive(1, i, 0, 0);
            cycle();
            chk("fill_af", 32'(almost_full), 32'(i >= 6));
        end
        drive(0, 0, 0, 0);
        chk("fill_count", 32'(count), 32'd8);
        chk("fill_drop", 32'(drop_cnt), 32'd2);
        chk("fill_ovf", 32'(overflow), 32'd1);
        drive(0, 0, 1, 0);
        for (int j = 1; j <= 8; j++) begin
            chk("fill_drain_order", 32'(bus.res_data), 32'(j));
            cycle();
        end
        drive(0, 0, 0, 1);
        cycle();

        // Full with simultaneous pop and push
        for (int i = 1; i <= 8; i++) begin
            drive(1, i, 0, 0);
            cycle();
        end
        drive(1, 99, 1, 0);
        cycle();
        drive(0, 0, 0, 0);
        chk("fullpp_count", 32'(count), 32'd8);
        chk("fullpp_drop", 32'(drop_cnt), 32'd0);
        chk("fullpp_head", 32'(bus.res_data), 32'd2);
        drain(7);
        chk("fullpp_last", 32'(bus.res_data), 32'd99);
        drain(1);

        // Clear racing a drop, then clear alone
        for (int i = 1; i <= 8; i++) begin
            drive(1, i, 0, 0);
            cycle();
        end
        drive(1, 50, 0, 0);
        cycle();
        drive(1, 51, 0, 1);
        cycle();
        drive(0, 0, 0, 0);
        chk("clr_drop_wins_cnt", 32'(drop_cnt), 32'd1);
        chk("clr_drop_wins_ovf", 32'(overflow), 32'd1);
        drive(0, 0, 0, 1);
        cycle();
        drive(0, 0, 0, 0);
        chk("clr_cnt", 32'(drop_cnt), 32'd0);
        chk("clr_ovf", 32'(overflow), 32'd0);
        chk("clr_count_kept", 32'(count), 32'd8);

        // Drop counter saturation
        drive(1, 33, 0, 0);
        for (int i = 0; i < 260; i++) cycle();
        drive(0, 0, 0, 0);
        chk("sat_drop", 32'(drop_cnt), 32'd255);
        drain(8);
        drive(0, 0, 0, 1);
        cycle();

        // Mid-stream reset
        for (int i = 0; i < 5; i++) begin
            drive(1, 20 + i, 0, 0);
            cycle();
        end
        drive(0, 0, 0, 0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("mrst_count", 32'(count), 32'd0);
        chk("mrst_valid", 32'(bus.res_valid), 32'd0);
        drive(1, 77, 0, 0);
        cycle();
        drive(0, 0, 0, 0);
        chk("mrst_first", 32'(bus.res_data), 32'd77);
        drain(1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 127),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
            chk("rand_no_x", 32'($isunknown(bus.res_data)), 32'd0);
            cycle();
        end
        drain(DEPTH);
        chk("rand_final_count", 32'(count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
